// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one request at a time, LATENCY wait states,
// registered response with read data and an error flag for misaligned/out-of-range accesses.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH];

  logic          access_s;
  logic          addr_err_s;
  logic          mem_wr_s;
  logic [AW-1:0] word_idx_s;

  assign addr_err_s = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign word_idx_s = addr_q[AW+1:2];
  assign access_s   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  // A reset landing on the access edge must keep a pending write out of memory.
  assign mem_wr_s   = access_s && we_q && !addr_err_s && !reset;

  // Outputs are forced quiet for as long as reset is held.
  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_rdata = reset ? 32'd0 : rsp_rdata_q;
  assign rsp_err   = rsp_err_q && !reset;

  // Next-state, request capture and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (addr_err_s) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
          end else if (we_q) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
          end else begin
            rsp_rdata_d = mem[word_idx_s];
            rsp_err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[word_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of transactions plus hand-written
// stall, reset-in-WAIT and latency (1 and 15) sequences.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_err;
  logic [31:0] l1_rsp_rdata;
  logic        l15_req_valid, l15_req_ready, l15_rsp_valid, l15_rsp_err;
  logic [31:0] l15_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH(64), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(l1_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(reset), .req_valid(l15_req_valid), .req_ready(l15_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(l15_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(l15_rsp_rdata), .rsp_err(l15_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request from a negedge, wait for acceptance, then scramble the inputs.
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    guard = 0;
    while (!req_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hA5A5_A5A5;
    req_wstrb = 4'b1111;
    check("ready_drop", 32'(req_ready), 32'd0);
  endtask

  // Called at the first negedge after acceptance; lat = edges from acceptance to rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check("rsp_timeout", 32'(lat < 40), 32'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_ready", 32'(req_ready), 32'd1);
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_rdata", rsp_rdata, 32'd0);
  endtask

  initial begin
    int lat;
    int lat1;
    int lat15;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'b0001, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'b1111, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,  32'h11223344, 4'b1100, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'h1122BEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'hFC,  32'h0BADF00D, 4'b1111, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h12,  32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'hFE,  32'h77777777, 4'b1111, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'hFC,  32'h0,        4'b0000, 32'h0BADF00D, 1'b0};
    vecs[11] = '{1'b0, 32'h100, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 32'h20,  32'h00000055, 4'b1111, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 32'h20,  32'h12345678, 4'b0000, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h20,  32'h0,        4'b0000, 32'h00000055, 1'b0};

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = 32'd0;
    req_wdata     = 32'd0;
    req_wstrb     = 4'd0;
    rsp_ready     = 1'b1;
    l1_req_valid  = 1'b0;
    l15_req_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      send_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      wait_rsp(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
      finish_rsp();
    end

    // Response stall with a competing request held on the request side.
    rsp_ready = 1'b0;
    send_req(1'b0, 32'h10, 32'h0, 4'b0000);
    wait_rsp(lat);
    check("stall_latency", 32'(lat), 32'(LAT));
    held      = 32'h1122BEAA;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'h0;
    req_wstrb = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, held);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_hs_ready", 32'(req_ready), 32'd1);
    check("stall_hs_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("stall_new_acc", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    check("stall_new_lat", 32'(lat), 32'(LAT));
    check("stall_new_rdata", rsp_rdata, 32'h00000055);
    finish_rsp();

    // Reset during WAIT of a write must abandon it.
    send_req(1'b1, 32'h20, 32'h00000099, 4'b1111);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("wrst_req_ready", 32'(req_ready), 32'd0);
    check("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("wrst_rel_ready", 32'(req_ready), 32'd1);
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) lat++;
    end
    check("wrst_no_rsp", 32'(lat), 32'd0);
    send_req(1'b0, 32'h20, 32'h0, 4'b0000);
    wait_rsp(lat);
    check("wrst_read_rdata", rsp_rdata, 32'h00000055);
    check("wrst_read_err", 32'(rsp_err), 32'd0);
    finish_rsp();

    // Latency 1 and 15 instances accept the same request on the same edge.
    @(negedge clk);
    req_we        = 1'b1;
    req_addr      = 32'h0;
    req_wdata     = 32'hCAFE0001;
    req_wstrb     = 4'b1111;
    l1_req_valid  = 1'b1;
    l15_req_valid = 1'b1;
    #1;
    check("l1_ready", 32'(l1_req_ready), 32'd1);
    check("l15_ready", 32'(l15_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    l1_req_valid  = 1'b0;
    l15_req_valid = 1'b0;
    lat1  = -1;
    lat15 = -1;
    for (int k = 0; k < 30; k++) begin
      if (l1_rsp_valid && lat1 < 0) begin
        lat1 = k;
        check("l1_err", 32'(l1_rsp_err), 32'd0);
      end
      if (l15_rsp_valid && lat15 < 0) begin
        lat15 = k;
        check("l15_err", 32'(l15_rsp_err), 32'd0);
      end
      @(negedge clk);
    end
    check("l1_latency", 32'(lat1), 32'd1);
    check("l15_latency", 32'(lat15), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
